// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared opcodes, constants and binary32 field types for fp_mod.
// Revision : 1.0  initial release
// ============================================================================
package fp_pkg;

   typedef logic [3:0] op_t;

   localparam op_t OP_ADD  = 4'd1;
   localparam op_t OP_SUB  = 4'd2;
   localparam op_t OP_MUL  = 4'd3;
   localparam op_t OP_DIV  = 4'd4;
   localparam op_t OP_SQRT = 4'd5;

   localparam int          BIAS    = 127;
   localparam logic [7:0]  EXP_MAX = 8'hFF;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
   } fp32_t;

   typedef logic [23:0] sig_t;

   // Denormals are flushed: a zero exponent yields a zero significand.
   function automatic sig_t sig_of(fp32_t f);
      return (f.exp == 8'd0) ? 24'd0 : {1'b1, f.man};
   endfunction

   function automatic logic signed [10:0] exp_ext(logic [7:0] e);
      return $signed({3'b000, e});
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_if
// Brief    : Operand/opcode and result/flag bundle of the FP execution unit.
// Revision : 1.0  initial release
// ============================================================================
interface fp_if;
   import fp_pkg::*;

   logic [31:0] a;
   logic [31:0] b;
   op_t         Op;
   logic [31:0] result;
   logic        Exception;
   logic        Underflow;
   logic        Overflow;

   modport master (
      output a, b, Op,
      input  result, Exception, Underflow, Overflow
   );

   modport slave (
      input  a, b, Op,
      output result, Exception, Underflow, Overflow
   );

endinterface
`default_nettype wire

// File: rtl/fp_sqrt_core.sv
`default_nettype none
// ============================================================================
// Module   : fp_sqrt_core
// Brief    : Combinational digit-by-digit integer square root, 48 in / 24 out.
// Revision : 1.0  initial release
// ============================================================================
module fp_sqrt_core (
   input  logic [47:0] rad,
   output logic [23:0] root
);

   always_comb begin : g_isqrt
      logic [26:0] rem;
      logic [25:0] trial;
      rem   = '0;
      trial = '0;
      root  = '0;
      for (int i = 23; i >= 0; i--) begin
         rem   = {rem[24:0], rad[2*i+1 -: 2]};
         trial = {root, 2'b01};
         if (rem >= {1'b0, trial}) begin
            rem  = rem - {1'b0, trial};
            root = {root[22:0], 1'b1};
         end else begin
            root = {root[22:0], 1'b0};
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fp_mod.sv
`default_nettype none
// ============================================================================
// Module   : fp_mod
// Brief    : binary32 add/sub/mul/div/sqrt, truncating, one-cycle registered.
// Revision : 1.0  initial release
// ============================================================================
module fp_mod (
   input  logic clk,
   input  logic rst_n,
   fp_if.slave  bus
);
   import fp_pkg::*;

   localparam logic signed [10:0] c_bias = 11'(BIAS);

   fp32_t w_fa, w_fb;
   sig_t  w_sa, w_sb;

   assign w_fa = bus.a;
   assign w_fb = bus.b;
   assign w_sa = sig_of(w_fa);
   assign w_sb = sig_of(w_fb);

   logic w_op_valid, w_uses_b, w_exc;

   assign w_op_valid = bus.Op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SQRT};
   assign w_uses_b   = (bus.Op != OP_SQRT);
   assign w_exc      = !w_op_valid
                     || (w_fa.exp == EXP_MAX)
                     || (w_uses_b && (w_fb.exp == EXP_MAX))
                     || ((bus.Op == OP_DIV) && (w_sb == 24'd0))
                     || ((bus.Op == OP_SQRT) && w_fa.sign && (w_sa != 24'd0));

   // ---------------- add / sub ----------------
   logic        w_sgn_beff, w_a_ge_b, w_sgn_l, w_sticky;
   logic [7:0]  w_exp_l, w_exp_s, w_diff;
   sig_t        w_ml, w_ms;
   logic [50:0] w_sh;
   logic [26:0] w_s27;
   logic [27:0] w_v;

   assign w_sgn_beff = w_fb.sign ^ (bus.Op == OP_SUB);
   assign w_a_ge_b   = {w_fa.exp, w_sa} >= {w_fb.exp, w_sb};
   assign w_exp_l    = w_a_ge_b ? w_fa.exp : w_fb.exp;
   assign w_exp_s    = w_a_ge_b ? w_fb.exp : w_fa.exp;
   assign w_ml       = w_a_ge_b ? w_sa : w_sb;
   assign w_ms       = w_a_ge_b ? w_sb : w_sa;
   assign w_sgn_l    = w_a_ge_b ? w_fa.sign : w_sgn_beff;
   assign w_diff     = w_exp_l - w_exp_s;

   // Guard/round/sticky below the LSB keep truncation exact on subtraction.
   assign w_sh     = {w_ms, 27'd0} >> w_diff;
   assign w_sticky = (w_diff > 8'd27) ? (|w_ms) : (|w_sh[23:0]);
   assign w_s27    = w_sh[50:24] | {26'd0, w_sticky};
   assign w_v      = (w_fa.sign == w_sgn_beff) ? ({1'b0, w_ml, 3'd0} + {1'b0, w_s27})
                                               : ({1'b0, w_ml, 3'd0} - {1'b0, w_s27});

   // ---------------- mul ----------------
   logic [47:0] w_p;
   assign w_p = w_sa * w_sb;

   // ---------------- div (restoring, 27 quotient bits) ----------------
   logic [26:0] w_q;

   always_comb begin : g_div
      logic [25:0] rem;
      rem = {2'b00, w_sa};
      w_q = '0;
      for (int i = 26; i >= 0; i--) begin
         if (rem >= {2'b00, w_sb}) begin
            w_q[i] = 1'b1;
            rem    = rem - {2'b00, w_sb};
         end
         rem = rem << 1;
      end
   end

   // ---------------- sqrt ----------------
   logic                w_odd;
   logic [24:0]         w_rad_m;
   logic signed [10:0]  w_sq_e, w_en_sqrt;
   logic [23:0]         w_root;

   assign w_odd     = ~w_fa.exp[0];
   assign w_rad_m   = w_odd ? {w_sa, 1'b0} : {1'b0, w_sa};
   assign w_sq_e    = exp_ext(w_fa.exp) - (w_odd ? 11'sd1 : 11'sd0) - c_bias;
   assign w_en_sqrt = (w_sq_e >>> 1) + c_bias;

   fp_sqrt_core u_sqrt (
      .rad  ({w_rad_m, 23'd0}),
      .root (w_root)
   );

   // ---------------- shared normalize / pack ----------------
   // w_n carries the magnitude with 1.0 at bit 46, scaled by 2^(w_en - 127).
   logic [47:0]        w_n;
   logic signed [10:0] w_en, w_en_norm;
   logic               w_sign, w_zsign;
   logic [5:0]         w_lz;
   logic [22:0]        w_sig;

   always_comb begin
      w_n     = '0;
      w_en    = '0;
      w_sign  = 1'b0;
      w_zsign = 1'b0;
      case (bus.Op)
         OP_ADD, OP_SUB: begin
            w_n    = {w_v, 20'd0};
            w_en   = exp_ext(w_exp_l);
            w_sign = w_sgn_l;
         end
         OP_MUL: begin
            w_n     = w_p;
            w_en    = exp_ext(w_fa.exp) + exp_ext(w_fb.exp) - c_bias;
            w_sign  = w_fa.sign ^ w_fb.sign;
            w_zsign = w_sign;
         end
         OP_DIV: begin
            w_n     = {1'b0, w_q, 20'd0};
            w_en    = exp_ext(w_fa.exp) - exp_ext(w_fb.exp) + c_bias;
            w_sign  = w_fa.sign ^ w_fb.sign;
            w_zsign = w_sign;
         end
         OP_SQRT: begin
            w_n     = {1'b0, w_root, 23'd0};
            w_en    = w_en_sqrt;
            w_sign  = w_fa.sign;
            w_zsign = w_fa.sign;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_lz = 6'd0;
      for (int i = 0; i < 48; i++) begin
         if (w_n[i]) w_lz = 6'(47 - i);
      end
   end

   assign w_sig     = 23'((w_n << w_lz) >> 24);
   assign w_en_norm = w_en + 11'sd1 - $signed({5'd0, w_lz});

   logic [31:0] w_result;
   logic        w_ovf, w_unf;

   always_comb begin
      w_result = '0;
      w_ovf    = 1'b0;
      w_unf    = 1'b0;
      if (w_exc) begin
         w_result = QNAN;
      end else if (w_n == 48'd0) begin
         w_result = {w_zsign, 31'd0};
      end else if (w_en_norm > 11'sd254) begin
         w_ovf    = 1'b1;
         w_result = {w_sign, EXP_MAX, 23'd0};
      end else if (w_en_norm < 11'sd1) begin
         w_unf    = 1'b1;
         w_result = {w_sign, 31'd0};
      end else begin
         w_result = {w_sign, w_en_norm[7:0], w_sig};
      end
   end

   logic [31:0] r_result;
   logic        r_exc, r_ovf, r_unf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_exc    <= 1'b0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         r_result <= w_result;
         r_exc    <= w_exc;
         r_ovf    <= w_ovf;
         r_unf    <= w_unf;
      end
   end

   assign bus.result    = r_result;
   assign bus.Exception = r_exc;
   assign bus.Overflow  = r_ovf;
   assign bus.Underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fp_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mod
// Brief    : Directed-vector self-checking bench for fp_mod.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_mod;
   import fp_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   fp_if bus ();

   fp_mod dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, want);
      end
   endtask

   // flg is {Exception, Overflow, Underflow}
   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [31:0] res, input logic [2:0] flg);
      @(negedge clk);
      bus.a  = a;
      bus.b  = b;
      bus.Op = op;
      @(posedge clk);
      #1;
      chk_val({tag, "/res"}, bus.result, res);
      chk_val({tag, "/flg"}, {29'd0, bus.Exception, bus.Overflow, bus.Underflow}, {29'd0, flg});
   endtask

   initial begin
      bus.a  = 32'h0;
      bus.b  = 32'h0;
      bus.Op = 4'd0;
      #1 rst_n = 1'b0;
      #2;
      chk_val("reset/res", bus.result, 32'h0);
      chk_val("reset/flg", {29'd0, bus.Exception, bus.Overflow, bus.Underflow}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run("add",  32'h44B4_2000, 32'h4224_0000, 4'd1, 32'h44B9_4000, 3'b000);
      run("sub",  32'h44B4_2000, 32'h4224_0000, 4'd2, 32'h44AF_0000, 3'b000);
      run("mul",  32'h44B4_2000, 32'h4224_0000, 4'd3, 32'h4766_C900, 3'b000);
      run("div",  32'h44B4_2000, 32'h4224_0000, 4'd4, 32'h420C_95DA, 3'b000);
      run("subn", 32'h4224_0000, 32'h44B4_2000, 4'd2, 32'hC4AF_0000, 3'b000);
      run("subs", 32'h3F80_0000, 32'h3080_0000, 4'd2, 32'h3F7F_FFFF, 3'b000);
      run("dnrm", 32'h0000_0001, 32'h3F80_0000, 4'd1, 32'h3F80_0000, 3'b000);

      run("sqrt1", 32'h44D2_2000, 32'h0000_0000, 4'd5, 32'h4224_0000, 3'b000);
      run("sqrt2", 32'h4010_0000, 32'h0000_0000, 4'd5, 32'h3FC0_0000, 3'b000);
      run("sqrtb", 32'h44D2_2000, 32'h7F80_0000, 4'd5, 32'h4224_0000, 3'b000);
      run("sqrtz", 32'h8000_0000, 32'h0000_0000, 4'd5, 32'h8000_0000, 3'b000);
      run("sqrtn", 32'hC000_0000, 32'h0000_0000, 4'd5, 32'h7FC0_0000, 3'b100);

      run("zadd", 32'h0, 32'h0, 4'd1, 32'h0, 3'b000);
      run("zsub", 32'h0, 32'h0, 4'd2, 32'h0, 3'b000);
      run("zmul", 32'h0, 32'h0, 4'd3, 32'h0, 3'b000);
      run("zdiv", 32'h0, 32'h4224_0000, 4'd4, 32'h0, 3'b000);
      run("div0", 32'h44B4_2000, 32'h0, 4'd4, 32'h7FC0_0000, 3'b100);
      run("inf",  32'h7F80_0000, 32'h3F80_0000, 4'd1, 32'h7FC0_0000, 3'b100);
      run("nanb", 32'h3F80_0000, 32'h7FC0_0000, 4'd3, 32'h7FC0_0000, 3'b100);

      run("ovf", 32'h7F00_0000, 32'h7F00_0000, 4'd3, 32'h7F80_0000, 3'b010);
      run("unf", 32'h0080_0000, 32'h0080_0000, 4'd3, 32'h0000_0000, 3'b001);

      run("op0",  32'h3F80_0000, 32'h3F80_0000, 4'd0, 32'h7FC0_0000, 3'b100);
      run("op9",  32'h3F80_0000, 32'h3F80_0000, 4'd9, 32'h7FC0_0000, 3'b100);
      run("same", 32'h45B2_11F7, 32'h45B2_11F7, 4'd2, 32'h0000_0000, 3'b000);

      // Asynchronous clear between edges, with flags set beforehand
      run("pre", 32'h3F80_0000, 32'h3F80_0000, 4'd9, 32'h7FC0_0000, 3'b100);
      #2 rst_n = 1'b0;
      #1;
      chk_val("arst/res", bus.result, 32'h0);
      chk_val("arst/flg", {29'd0, bus.Exception, bus.Overflow, bus.Underflow}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      run("post", 32'h44B4_2000, 32'h4224_0000, 4'd1, 32'h44B9_4000, 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
